mvm_row_sequencer: RTL and testbench

- Control-side counterpart of the pipelined dot-product unit (ROW_N multipliers plus an adder tree, 2-cycle latency).
- Captures one input vector and streams COL_M weight rows from a synchronous weight RAM into the dot-product unit, one row per cycle.
- Tracks each row's result through the unit's pipeline and assembles the COL_M scalar results into an output vector.
- Hands the output vector to the LSTM gate logic over a valid/ready handshake.

---
 rtl/mvm_row_sequencer.sv | 142 ++++++++++++++
 tb/tb_mvm_row_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_row_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mvm_row_sequencer
//  Description : Control sequencer for a pipelined dot-product unit. Captures
//                one input vector, streams COL_M weight rows out of a
//                synchronous weight RAM (one row per cycle), follows each row
//                through the dot-product pipeline with a valid-tag shift
//                register, and assembles the scalar results into an output
//                vector that is offered over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module mvm_row_sequencer #(
    parameter int ROW_N     = 8,
    parameter int LSTM_XLEN = 16,
    parameter int COL_M     = 8,
    parameter int ADDR_W    = 3,
    parameter int PIPE_LAT  = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [ROW_N*LSTM_XLEN-1:0]   vec_in,
    output logic                         busy,
    output logic                         w_rd_en,
    output logic [ADDR_W-1:0]            w_rd_addr,
    input  logic [ROW_N*LSTM_XLEN-1:0]   w_rd_data,
    output logic [ROW_N*LSTM_XLEN-1:0]   dp_input_vec,
    output logic [ROW_N*LSTM_XLEN-1:0]   dp_weight_row,
    input  logic [LSTM_XLEN-1:0]         dp_result,
    output logic [COL_M*LSTM_XLEN-1:0]   out_vec,
    output logic                         out_valid,
    input  logic                         out_ready
);

    // Counters must be able to represent COL_M itself.
    localparam int CNT_W = $clog2(COL_M + 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(COL_M - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                        state_q;
    logic [CNT_W-1:0]              issue_cnt_q;
    logic [CNT_W-1:0]              cap_cnt_q;
    logic [PIPE_LAT:0]             tag_q;
    logic [PIPE_LAT:0]             tag_d;
    logic                          capture_d;
    logic                          busy_q;
    logic                          w_rd_en_q;
    logic [ADDR_W-1:0]             w_rd_addr_q;
    logic [ROW_N*LSTM_XLEN-1:0]    dp_input_vec_q;
    logic [COL_M*LSTM_XLEN-1:0]    out_vec_q;
    logic                          out_valid_q;

    // The RAM samples the address on the edge after w_rd_en_q is set, so the
    // registered read enable is exactly the "row entered the RAM" tag. After
    // 1+PIPE_LAT shifts the tag lines up with that row's dot-product result.
    always_comb begin
        tag_d    = tag_q << 1;
        tag_d[0] = w_rd_en_q;
        capture_d = tag_q[PIPE_LAT] && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
    end

    // Sequencer FSM, tag pipe, result capture and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            issue_cnt_q    <= '0;
            cap_cnt_q      <= '0;
            tag_q          <= '0;
            busy_q         <= 1'b0;
            w_rd_en_q      <= 1'b0;
            w_rd_addr_q    <= '0;
            dp_input_vec_q <= '0;
            out_vec_q      <= '0;
            out_valid_q    <= 1'b0;
        end else begin
            tag_q <= tag_d;

            // Results land in order, so the capture counter is the element index.
            if (capture_d) begin
                out_vec_q[cap_cnt_q*LSTM_XLEN +: LSTM_XLEN] <= dp_result;
                cap_cnt_q <= cap_cnt_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dp_input_vec_q <= vec_in;
                        issue_cnt_q    <= '0;
                        cap_cnt_q      <= '0;
                        w_rd_en_q      <= 1'b1;
                        w_rd_addr_q    <= '0;
                        busy_q         <= 1'b1;
                        state_q        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Row issue_cnt_q is on the RAM port this cycle.
                    if (issue_cnt_q == LAST_ROW) begin
                        w_rd_en_q <= 1'b0;
                        state_q   <= S_DRAIN;
                    end else begin
                        issue_cnt_q <= issue_cnt_q + 1'b1;
                        w_rd_addr_q <= ADDR_W'(issue_cnt_q + 1'b1);
                    end
                end
                S_DRAIN: begin
                    // The last result capture completes the vector.
                    if (capture_d && (cap_cnt_q == LAST_ROW)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign w_rd_en       = w_rd_en_q;
    assign w_rd_addr     = w_rd_addr_q;
    assign dp_input_vec  = dp_input_vec_q;
    assign dp_weight_row = w_rd_data;
    assign out_vec       = out_vec_q;
    assign out_valid     = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mvm_row_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mvm_row_sequencer
//  Description : Self-checking bench for mvm_row_sequencer with a weight RAM
//                model, a 2-stage dot-product model and a reference product.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mvm_row_sequencer;

    localparam int ROW_N = 8;
    localparam int X     = 16;
    localparam int COL_M = 8;
    localparam int AW    = 3;
    localparam int PL    = 2;
    localparam int VW    = ROW_N * X;
    localparam int OW    = COL_M * X;
    localparam int EXP_LAT = COL_M + 1 + PL;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [VW-1:0] vec_in = '0;
    logic          busy;
    logic          w_rd_en;
    logic [AW-1:0] w_rd_addr;
    logic [VW-1:0] w_rd_data = '0;
    logic [VW-1:0] dp_input_vec;
    logic [VW-1:0] dp_weight_row;
    logic [X-1:0]  dp_result = '0;
    logic [X-1:0]  dp_s1 = '0;
    logic [OW-1:0] out_vec;
    logic          out_valid;
    logic          out_ready = 1'b0;

    logic [VW-1:0] mem [COL_M];

    int vectors = 0;
    int errors  = 0;

    // Address monitor state
    logic          mon_on = 1'b0;
    logic          prev_en = 1'b0;
    int            en_runs = 0;
    logic [AW-1:0] addrs[$];

    logic [OW-1:0] exp_vec;
    logic [OW-1:0] prev_vec;
    int            lat;
    logic          stable;

    mvm_row_sequencer #(
        .ROW_N(ROW_N), .LSTM_XLEN(X), .COL_M(COL_M), .ADDR_W(AW), .PIPE_LAT(PL)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .vec_in(vec_in),
        .busy(busy), .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr),
        .w_rd_data(w_rd_data), .dp_input_vec(dp_input_vec),
        .dp_weight_row(dp_weight_row), .dp_result(dp_result),
        .out_vec(out_vec), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clock = ~clock;

    // Dot product of two packed rows, modulo 2^X.
    function automatic logic [X-1:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [X-1:0] acc;
        logic [X-1:0] ea;
        logic [X-1:0] eb;
        acc = '0;
        for (int i = 0; i < ROW_N; i++) begin
            ea  = a[i*X +: X];
            eb  = b[i*X +: X];
            acc = acc + X'(ea * eb);
        end
        return acc;
    endfunction

    // Expected output: element k is the product of vector v with weight row k.
    function automatic logic [OW-1:0] ref_model(input logic [VW-1:0] v);
        logic [OW-1:0] r;
        r = '0;
        for (int k = 0; k < COL_M; k++) r[k*X +: X] = dot(v, mem[k]);
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < VW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Synchronous weight RAM and 2-cycle dot-product unit.
    always @(posedge clock) begin
        if (w_rd_en) w_rd_data <= mem[w_rd_addr];
        dp_s1     <= dot(dp_input_vec, dp_weight_row);
        dp_result <= dp_s1;
    end

    // Record the RAM read stream during a monitored product.
    always @(posedge clock) begin
        if (mon_on) begin
            if (w_rd_en) addrs.push_back(w_rd_addr);
            if (w_rd_en && !prev_en) en_runs++;
            prev_en = w_rd_en;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_product(input logic [VW-1:0] v);
        addrs.delete();
        en_runs = 0;
        prev_en = 1'b0;
        mon_on  = 1'b1;
        exp_vec = ref_model(v);
        vec_in  = v;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        vec_in  = rand_vec();
    endtask

    task automatic wait_done(input int from, output int l);
        l = from;
        while (!out_valid && l < 40) begin
            tick();
            l++;
        end
        mon_on = 1'b0;
    endtask

    task automatic check_addrs();
        check("rd_count", 256'(addrs.size()), 256'(COL_M));
        check("rd_runs", 256'(en_runs), 256'd1);
        for (int i = 0; i < addrs.size() && i < COL_M; i++)
            check("rd_addr", 256'(addrs[i]), 256'(i));
    endtask

    initial begin
        for (int k = 0; k < COL_M; k++)
            for (int i = 0; i < ROW_N; i++) mem[k][i*X +: X] = X'(k);

        // Reset state
        tick(); tick();
        reset = 1'b0;
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_en", 256'(w_rd_en), 256'd0);
        check("rst_addr", 256'(w_rd_addr), 256'd0);
        check("rst_dpvec", 256'(dp_input_vec), 256'd0);
        check("rst_outvec", 256'(out_vec), 256'd0);
        check("rst_valid", 256'(out_valid), 256'd0);

        // Basic product: all-ones vector, row k filled with k -> element k = 8k
        begin
            logic [VW-1:0] ones;
            for (int i = 0; i < ROW_N; i++) ones[i*X +: X] = X'(1);
            start_product(ones);
            check("busy_after_start", 256'(busy), 256'd1);
            wait_done(0, lat);
            check("basic_latency", 256'(lat), 256'(EXP_LAT));
            for (int k = 0; k < COL_M; k++) check("basic_elem", 256'(out_vec[k*X +: X]), 256'(8 * k));
            check_addrs();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("accept_idle", 256'(busy), 256'd0);

        // Random weights from here on
        for (int k = 0; k < COL_M; k++) mem[k] = rand_vec();

        // Start pulsed during ISSUE is ignored
        start_product(rand_vec());
        tick(); tick();
        start  = 1'b1;
        vec_in = rand_vec();
        tick();
        start  = 1'b0;
        wait_done(3, lat);
        check("ign_latency", 256'(lat), 256'(EXP_LAT));
        check("ign_result", 256'(out_vec), 256'(exp_vec));
        check_addrs();

        // Start in HOLD ignored, then 20 cycles of backpressure
        start = 1'b1;
        tick();
        start = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!(out_valid === 1'b1 && busy === 1'b1 && out_vec === exp_vec)) stable = 1'b0;
        end
        check("bp_stable", 256'(stable), 256'd1);
        check("bp_valid", 256'(out_valid), 256'd1);
        check("bp_vec", 256'(out_vec), 256'(exp_vec));

        // Handshake edge with start: goes IDLE, start ignored
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("hs_busy", 256'(busy), 256'd0);
        check("hs_valid", 256'(out_valid), 256'd0);
        tick();
        check("hs_no_restart", 256'(busy), 256'd0);
        check("hs_en", 256'(w_rd_en), 256'd0);

        // Fresh product in IDLE with new vector
        start_product(rand_vec());
        wait_done(0, lat);
        check("fresh_latency", 256'(lat), 256'(EXP_LAT));
        check("fresh_result", 256'(out_vec), 256'(exp_vec));

        // Back-to-back: accept and restart on the first IDLE cycle
        prev_vec  = out_vec;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        start_product(rand_vec());
        tick(); tick(); tick();
        check("b2b_old_kept", 256'(out_vec), 256'(prev_vec));
        wait_done(3, lat);
        check("b2b_latency", 256'(lat), 256'(EXP_LAT));
        check("b2b_result", 256'(out_vec), 256'(exp_vec));
        check_addrs();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset asserted at edge 5 after start
        start_product(rand_vec());
        tick(); tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        mon_on = 1'b0;
        check("mid_rst_busy", 256'(busy), 256'd0);
        check("mid_rst_valid", 256'(out_valid), 256'd0);
        check("mid_rst_vec", 256'(out_vec), 256'd0);
        for (int i = 0; i < 6; i++) tick();
        check("mid_rst_no_stale", 256'(out_vec), 256'd0);
        check("mid_rst_idle", 256'(busy), 256'd0);

        start_product(rand_vec());
        wait_done(0, lat);
        check("post_rst_latency", 256'(lat), 256'(EXP_LAT));
        check("post_rst_result", 256'(out_vec), 256'(exp_vec));
        check_addrs();

        // A few more random products
        for (int n = 0; n < 4; n++) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            for (int k = 0; k < COL_M; k++) mem[k] = rand_vec();
            start_product(rand_vec());
            wait_done(0, lat);
            check("rand_latency", 256'(lat), 256'(EXP_LAT));
            check("rand_result", 256'(out_vec), 256'(exp_vec));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
